// File: rtl/hpdcache_fence_seq.sv
// Fence/flush sequencer between the load-store unit and the HPDcache.
// Tracks outstanding stores, throttles new stores at the credit limit, and on a
// fence drains outstanding stores and optionally flushes the dcache.
// Optional watchdog: define HPDCACHE_FENCE_TIMEOUT_EN to abort stuck fences.
module hpdcache_fence_seq #(
   parameter int unsigned MaxOutstandingStores = 7,
   parameter bit          FlushOnFence         = 1'b1,
   parameter int unsigned TimeoutCycles        = 1024,
   parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                fence_valid_i,
   output logic                fence_ready_o,
   output logic                fence_done_o,
   input  logic                store_issue_i,
   input  logic                store_ack_i,
   output logic                store_stall_o,
   output logic                flush_valid_o,
   input  logic                flush_ready_i,
   input  logic                flush_done_i,
   output logic [CntWidth-1:0] outstanding_o,
   output logic                busy_o,
   output logic                timeout_o
);

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StFlushReq,
      StFlushWait,
      StDone
   } state_e;

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstandingStores);

   state_e              state_q, state_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic                fence_acc;
   logic                store_inc;
   logic                store_dec;
   logic                timeout_hit;

   assign fence_ready_o = (state_q == StIdle);
   assign fence_acc     = fence_valid_i & fence_ready_o;
   // No new stores while a fence is in flight, so the drain always terminates.
   assign store_stall_o = (count_q == MaxCnt) | (state_q != StIdle);
   assign store_inc     = store_issue_i & ~store_stall_o;
   // Acks at zero are spurious; dropping them keeps the counter from wrapping.
   assign store_dec     = store_ack_i & (count_q != '0);

   assign flush_valid_o = (state_q == StFlushReq);
   assign fence_done_o  = (state_q == StDone);
   assign busy_o        = (state_q != StIdle);
   assign outstanding_o = count_q;

   // Outstanding-store counter next state; simultaneous issue and ack cancel.
   always_comb begin
      count_d = count_q;
      if (store_inc && !store_dec) begin
         count_d = count_q + CntWidth'(1);
      end else if (store_dec && !store_inc) begin
         count_d = count_q - CntWidth'(1);
      end
   end

`ifdef HPDCACHE_FENCE_TIMEOUT_EN
   localparam int unsigned        TmrWidth = $clog2(TimeoutCycles + 1);
   localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(TimeoutCycles - 1);

   logic [TmrWidth-1:0] tmr_q, tmr_d;
   logic                timeout_q;
   logic                fence_active;

   assign fence_active = (state_q == StDrain) | (state_q == StFlushReq) |
                         (state_q == StFlushWait);
   // Fires on the last permitted waiting cycle so DONE follows immediately.
   assign timeout_hit  = fence_active & (tmr_q == TmrLast);
   assign timeout_o    = timeout_q;

   // Watchdog counts only while waiting on the cache; cleared otherwise.
   always_comb begin
      tmr_d = '0;
      if (fence_active) begin
         tmr_d = tmr_q + TmrWidth'(1);
      end
   end

   // Watchdog registers; the error flag is sticky until reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   // Fence sequencing: drain, optional flush handshake, one-cycle done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (fence_acc) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (count_q == '0) begin
               state_d = FlushOnFence ? StFlushReq : StDone;
            end
         end
         StFlushReq: begin
            if (flush_ready_i) begin
               state_d = StFlushWait;
            end
         end
         StFlushWait: begin
            if (flush_done_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Watchdog abort still completes the fence so the requester is released.
      if (timeout_hit) begin
         state_d = StDone;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   cov_ack_at_zero: cover property (@(posedge clk_i) disable iff (rst_i)
      store_ack_i && (count_q == '0));

   cfg_sane: assert property (@(posedge clk_i)
      (TimeoutCycles > 1) && (MaxOutstandingStores > 0));

endmodule

// File: tb/tb_hpdcache_fence_seq.sv
// Scoreboard bench for hpdcache_fence_seq. Three instances share one stimulus
// driver: default config, drain-only (no flush), and a short watchdog.
module tb_hpdcache_fence_seq;

   localparam int Cw    = 3;
   localparam int MaxSt = 7;
`ifdef HPDCACHE_FENCE_TIMEOUT_EN
   localparam int LimC     = 16;
   localparam int LongWait = 1000;
`else
   localparam int LimC     = 0;
   localparam int LongWait = 60;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] sel;
   logic       drv_fv, drv_iss, drv_ack, drv_fr, drv_fd;
   logic [2:0] in_fv, in_iss, in_ack, in_fr, in_fd;
   logic [2:0] o_ready, o_done, o_stall, o_fvl, o_busy, o_tmo;
   logic [Cw-1:0] o_cnt [3];

   assign in_fv  = drv_fv  ? (3'b001 << sel) : 3'b000;
   assign in_iss = drv_iss ? (3'b001 << sel) : 3'b000;
   assign in_ack = drv_ack ? (3'b001 << sel) : 3'b000;
   assign in_fr  = drv_fr  ? (3'b001 << sel) : 3'b000;
   assign in_fd  = drv_fd  ? (3'b001 << sel) : 3'b000;

   hpdcache_fence_seq u_dut_a (
      .clk_i(clk), .rst_i(rst), .fence_valid_i(in_fv[0]), .fence_ready_o(o_ready[0]),
      .fence_done_o(o_done[0]), .store_issue_i(in_iss[0]), .store_ack_i(in_ack[0]),
      .store_stall_o(o_stall[0]), .flush_valid_o(o_fvl[0]), .flush_ready_i(in_fr[0]),
      .flush_done_i(in_fd[0]), .outstanding_o(o_cnt[0]), .busy_o(o_busy[0]),
      .timeout_o(o_tmo[0])
   );

   hpdcache_fence_seq #(.FlushOnFence(1'b0)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .fence_valid_i(in_fv[1]), .fence_ready_o(o_ready[1]),
      .fence_done_o(o_done[1]), .store_issue_i(in_iss[1]), .store_ack_i(in_ack[1]),
      .store_stall_o(o_stall[1]), .flush_valid_o(o_fvl[1]), .flush_ready_i(in_fr[1]),
      .flush_done_i(in_fd[1]), .outstanding_o(o_cnt[1]), .busy_o(o_busy[1]),
      .timeout_o(o_tmo[1])
   );

   hpdcache_fence_seq #(.TimeoutCycles(16)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .fence_valid_i(in_fv[2]), .fence_ready_o(o_ready[2]),
      .fence_done_o(o_done[2]), .store_issue_i(in_iss[2]), .store_ack_i(in_ack[2]),
      .store_stall_o(o_stall[2]), .flush_valid_o(o_fvl[2]), .flush_ready_i(in_fr[2]),
      .flush_done_i(in_fd[2]), .outstanding_o(o_cnt[2]), .busy_o(o_busy[2]),
      .timeout_o(o_tmo[2])
   );

   typedef struct {
      int            cyc;
      logic [Cw-1:0] cnt;
      logic          stall, fvl, busy, done, ready, tmo;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input int cyc, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, want);
      end
   endtask

   // Monitor: pops one expected snapshot per checked cycle, away from the edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("outstanding", mon_e.cyc, int'(o_cnt[sel]), int'(mon_e.cnt));
            chk("store_stall", mon_e.cyc, int'(o_stall[sel]), int'(mon_e.stall));
            chk("flush_valid", mon_e.cyc, int'(o_fvl[sel]), int'(mon_e.fvl));
            chk("busy", mon_e.cyc, int'(o_busy[sel]), int'(mon_e.busy));
            chk("fence_done", mon_e.cyc, int'(o_done[sel]), int'(mon_e.done));
            chk("fence_ready", mon_e.cyc, int'(o_ready[sel]), int'(mon_e.ready));
            chk("timeout", mon_e.cyc, int'(o_tmo[sel]), int'(mon_e.tmo));
         end
      end
   end

   // Reference model: a fence is a timeline planned when it is accepted.
   int  n;
   int  m_cnt;
   bit  f_act;
   int  f_t, f_z, f_r, f_d, f_done, f_la;
   int  acks[$];
   bit  tmo_set;
   int  tmo_cyc;
   bit  cfg_flush;
   int  cfg_lim;
   bit  chk_en;
   logic [1:0] sel_req;
   // Table entry: {plan_mode[1:0], rst, fence_valid, issue, ack}
   logic [5:0] tab[$];

   localparam logic [5:0] TIdle = 6'b00_0000, TIss = 6'b00_0010, TAck = 6'b00_0001;
   localparam logic [5:0] TIa = 6'b00_0011, TRst = 6'b00_1000, TFv = 6'b00_0100;
   localparam logic [5:0] TFvMin = 6'b01_0100, TFvGap = 6'b10_0100, TFvLong = 6'b11_0100;

   task automatic plan(input int c, input int pm);
      int gap, r, d, nat;
      f_act = 1'b1;
      f_t   = n;
      f_la  = n;
      acks.delete();
      for (int k = 0; k < c; k++) begin
         gap  = (pm == 2) ? 3 : ((pm == 0) ? 1 + int'($urandom_range(0, 3)) : 1);
         f_la = f_la + gap;
         acks.push_back(f_la);
      end
      f_z = (c == 0) ? n + 1 : f_la + 1;
      r   = (pm == 0) ? int'($urandom_range(0, 3)) : 0;
      d   = (pm == 0) ? int'($urandom_range(0, 4)) : (pm == 2) ? 1 : (pm == 3) ? LongWait : 0;
      f_r = f_z + 1 + r;
      f_d = f_r + 1 + d;
      nat = cfg_flush ? f_d + 1 : f_z + 1;
      if (cfg_lim > 0 && nat >= n + 1 + cfg_lim) begin
         f_done = n + 1 + cfg_lim;
         if (!tmo_set) begin
            tmo_set = 1'b1;
            tmo_cyc = f_done;
         end
      end else begin
         f_done = nat;
      end
   endtask

   task automatic step();
      logic [5:0] t;
      bit busy, stall, v_rst, v_fv, v_iss, v_ack, v_fr, v_fd;
      int pm, nxt;
      exp_t e;
      @(negedge clk);
      sel = sel_req;
      n++;
      busy  = f_act && (n > f_t);
      stall = busy || (m_cnt == MaxSt);
      if (chk_en) begin
         e.cyc   = n;
         e.cnt   = Cw'(m_cnt);
         e.stall = stall;
         e.busy  = busy;
         e.ready = !busy;
         e.done  = f_act && (n == f_done);
         e.fvl   = f_act && cfg_flush && (n > f_z) && (n <= f_r) && (n < f_done);
         e.tmo   = tmo_set && (n >= tmo_cyc);
         exp_q.push_back(e);
      end
      v_fr = ($urandom_range(0, 1) == 1);
      v_fd = ($urandom_range(0, 3) == 0);
      if (tab.size() > 0) begin
         t     = tab.pop_front();
         pm    = int'(t[5:4]);
         v_rst = t[3];
         v_fv  = t[2];
         v_iss = t[1];
         v_ack = t[0];
      end else begin
         pm    = 0;
         v_rst = ($urandom_range(0, 255) == 0);
         v_fv  = busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
         v_iss = ($urandom_range(0, 1) == 1);
         v_ack = ($urandom_range(0, 2) == 0);
      end
      if (busy) begin
         v_ack = 1'b0;
         if (acks.size() > 0 && acks[0] == n) begin
            v_ack = 1'b1;
            void'(acks.pop_front());
         end else if (n > f_la) begin
            v_ack = ($urandom_range(0, 3) == 0);
         end
         if (n > f_z && n < f_r) v_fr = 1'b0;
         else if (n == f_r) v_fr = 1'b1;
         if (n > f_r && n < f_d) v_fd = 1'b0;
         else if (n == f_d) v_fd = 1'b1;
      end
      rst     = v_rst;
      drv_fv  = v_fv;
      drv_iss = v_iss;
      drv_ack = v_ack;
      drv_fr  = v_fr;
      drv_fd  = v_fd;
      if (v_rst) begin
         m_cnt   = 0;
         f_act   = 1'b0;
         tmo_set = 1'b0;
         acks.delete();
      end else begin
         nxt = m_cnt + ((v_iss && !stall) ? 1 : 0) - ((v_ack && m_cnt > 0) ? 1 : 0);
         if (f_act && n == f_done) begin
            f_act = 1'b0;
            acks.delete();
         end
         if (!busy && v_fv) plan(nxt, pm);
         m_cnt = nxt;
      end
   endtask

   task automatic run_phase(input logic [1:0] s, input bit fl, input int lim, input int len);
      sel_req   = s;
      cfg_flush = fl;
      cfg_lim   = lim;
      chk_en    = 1'b0;
      tab.push_front(TRst);
      step();
      chk_en = 1'b1;
      for (int i = 0; i < len; i++) step();
   endtask

   initial begin
      rst = 1'b1; sel = 2'd0; sel_req = 2'd0;
      drv_fv = 1'b0; drv_iss = 1'b0; drv_ack = 1'b0; drv_fr = 1'b0; drv_fd = 1'b0;
      n = 0; m_cnt = 0; f_act = 1'b0; tmo_set = 1'b0; tmo_cyc = 0; chk_en = 1'b0;
      f_t = 0; f_z = 0; f_r = 0; f_d = 0; f_done = 0; f_la = 0;
      cfg_flush = 1'b1; cfg_lim = 0;
      repeat (2) @(negedge clk);

      // Saturation, cancel, ack at zero, minimum-latency fence, two-ack drain.
      repeat (8) tab.push_back(TIss);
      repeat (4) tab.push_back(TAck);
      tab.push_back(TIa);
      repeat (3) tab.push_back(TAck);
      tab.push_back(TAck);
      tab.push_back(TFvMin);
      repeat (6) tab.push_back(TIdle);
      repeat (2) tab.push_back(TIss);
      tab.push_back(TFvGap);
      repeat (14) tab.push_back(TIdle);
      run_phase(2'd0, 1'b1, 0, 800);

      tab.push_back(TFvMin);
      repeat (5) tab.push_back(TIdle);
      repeat (2) tab.push_back(TIss);
      tab.push_back(TFv);
      run_phase(2'd1, 1'b0, 0, 400);

      // Flush never completes: watchdog abort (or indefinite wait), then reset.
      tab.push_back(TFvLong);
      repeat (24) tab.push_back(TIdle);
      tab.push_back(TRst);
      repeat (3) tab.push_back(TIdle);
      run_phase(2'd2, 1'b1, LimC, 500);

      tab.push_back(TRst);
      repeat (3) tab.push_back(TIdle);
      repeat (4) step();
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
